// File: rtl/arb_bus_pkg.sv
// ---------------------------------------------------------------------------
// arb_bus_pkg : shared types and defaults for the arbiter slave responder
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arb_bus_pkg;

  localparam int DEF_HOSTS  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;
  localparam int DEF_CPU_W  = $clog2(DEF_HOSTS);

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_BAD} op_t;

  function automatic op_t decode_op(input logic rd, input logic wr);
    if (rd && wr) return OP_BAD;
    if (wr)       return OP_WR;
    return OP_RD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arb_bus_slave_ram.sv
// ---------------------------------------------------------------------------
// arb_bus_slave_ram : word array, byte-lane synchronous write, async read
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_bus_slave_ram
  import arb_bus_pkg::*;
#(
  parameter int  DEPTH  = 256,
  parameter int  DATA_W = DEF_DATA_W,
  localparam int BE_W   = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

`default_nettype wire

// File: rtl/arb_bus_slave.sv
// ---------------------------------------------------------------------------
// arb_bus_slave : wait-state memory target with range/protocol/WP checking
// rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_bus_slave
  import arb_bus_pkg::*;
#(
  parameter int               HOSTS       = DEF_HOSTS,
  parameter int               ADDR_W      = DEF_ADDR_W,
  parameter int               DATA_W      = DEF_DATA_W,
  parameter int               DEPTH       = 256,
  parameter int               WAIT_CYCLES = 2,
  parameter logic [HOSTS-1:0] WP_MASK     = '0,
  localparam int              CPU_W       = $clog2(HOSTS),
  localparam int              BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] add_bus,
  input  logic [BE_W-1:0]   byte_en,
  input  logic              wr_bus,
  input  logic              rd_bus,
  input  logic [DATA_W-1:0] data_bus_wr,
  input  logic [CPU_W-1:0]  cpu_bus,
  output logic [DATA_W-1:0] data_bus_rd,
  output logic              ack_bus,
  output logic              err_bus,
  output logic [CPU_W-1:0]  last_cpu
);

  localparam int              IDX_W      = $clog2(DEPTH);
  localparam int              CNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * BE_W);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [BE_W-1:0]   cap_be;
  logic [DATA_W-1:0] cap_data;
  logic [CPU_W-1:0]  cap_cpu;
  op_t               cap_op;

  logic              out_of_range;
  logic              txn_err;
  logic              commit;
  logic [DATA_W-1:0] ram_rdata;

  // All checks use the captured request so mid-wait bus changes are ignored.
  assign out_of_range = ({1'b0, cap_addr} >= ADDR_LIMIT);
  assign txn_err      = out_of_range || (cap_op == OP_BAD) ||
                        ((cap_op == OP_WR) && WP_MASK[cap_cpu]);
  assign commit       = (state == WAIT) && (cnt == '0) && (cap_op == OP_WR) && !txn_err;

  arb_bus_slave_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (commit),
    .idx   (cap_addr[IDX_W+1:2]),
    .be    (cap_be),
    .wdata (cap_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_addr    <= '0;
      cap_be      <= '0;
      cap_data    <= '0;
      cap_cpu     <= '0;
      cap_op      <= OP_RD;
      ack_bus     <= 1'b0;
      err_bus     <= 1'b0;
      data_bus_rd <= '0;
      last_cpu    <= '0;
    end else begin
      ack_bus <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_bus || wr_bus) begin
            cap_addr <= add_bus;
            cap_be   <= byte_en;
            cap_data <= data_bus_wr;
            cap_cpu  <= cpu_bus;
            cap_op   <= decode_op(rd_bus, wr_bus);
            cnt      <= CNT_W'(WAIT_CYCLES);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state    <= ACK;
            ack_bus  <= 1'b1;
            err_bus  <= txn_err;
            last_cpu <= cap_cpu;
            if (txn_err)               data_bus_rd <= DATA_W'(ERR_DATA);
            else if (cap_op == OP_WR)  data_bus_rd <= '0;
            else                       data_bus_rd <= ram_rdata;
          end
        end
        ACK:  state <= HOLD;
        // Strobes must be seen low once before another request is taken.
        HOLD: if (!rd_bus && !wr_bus) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/arb_bus_slave.md
Name: arb_bus_slave

Overview:
- Memory-mapped responder on the shared slave side of the 4-host round-robin arbiter.
- Accepts the single granted transaction: add_bus, byte_en, wr_bus, rd_bus, data_bus_wr, cpu_bus.
- Returns data_bus_rd and a one-cycle ack_bus after a programmable wait-state count, so the arbiter and its testbench have a real, timing-controllable target.
- Adds range checking and per-host write protection, reported through an error flag that is qualified by ack.

Parameters:
- HOSTS, 4, number of arbiter hosts; CPU_W = $clog2(HOSTS).
- ADDR_W, 32, address bus width.
- DATA_W, 32, data bus width; BE_W = DATA_W/8.
- DEPTH, 256, number of DATA_W words; index = add_bus[$clog2(DEPTH)+1:2].
- WAIT_CYCLES, 2, wait states inserted before ack (0 allowed).
- WP_MASK, 4'b0000, bit h=1 makes host h read-only.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- add_bus  in  ADDR_W  byte address of granted transaction.
- byte_en  in  BE_W  write byte lanes.
- wr_bus  in  1  write strobe, held until ack.
- rd_bus  in  1  read strobe, held until ack.
- data_bus_wr  in  DATA_W  write data.
- cpu_bus  in  CPU_W  id of granted host.
- data_bus_rd  out  DATA_W  read data, valid while ack_bus=1.
- ack_bus  out  1  one-cycle completion pulse.
- err_bus  out  1  error flag, meaningful only with ack_bus.
- last_cpu  out  CPU_W  cpu_bus of the last completed transaction.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Outputs: ack_bus=0, err_bus=0, data_bus_rd=0, last_cpu=0.
  - FSM goes to IDLE and the wait counter clears to 0.
  - Memory contents are not cleared.
  - Reset mid-transaction aborts it: no write is committed and no ack is issued.
- FSM states: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - On an edge with rd_bus|wr_bus=1, capture address, byte_en, data, cpu and op.
  - Load the counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - When counter≠0, decrement.
  - When counter=0, go to ACK.
  - At that same edge:
    - register ack_bus=1;
    - commit the write;
    - register data_bus_rd;
    - register err_bus;
    - update last_cpu.
- Latency: ack_bus is high in the cycle beginning WAIT_CYCLES+1 edges after the sampling edge. With WAIT_CYCLES=0 this is the next cycle.
- ACK lasts exactly one cycle; ack_bus returns to 0 and the FSM goes to HOLD.
- HOLD: stay until rd_bus=0 and wr_bus=0 are sampled, then go to IDLE.
  - A new transaction is therefore accepted no earlier than one idle-strobe cycle after ack.
  - Back-to-back grants to different hosts still need the strobes to drop for one cycle.
- Captured values are used throughout. Input changes during WAIT are ignored.
- Errors: ack is always issued. If any of the following holds, err_bus=1, no write is committed, and data_bus_rd=32'hDEAD_BEEF:
  - address ≥ DEPTH*BE_W (out of range);
  - rd_bus and wr_bus both 1 at capture (protocol error);
  - a write from a host whose WP_MASK bit is set.
- Reads: data_bus_rd = mem[index], err_bus=0.
  - data_bus_rd holds its value after ack until the next ack.
- Writes:
  - Each byte lane i with byte_en[i]=1 is updated; other lanes are kept.
  - byte_en=0 is a legal no-op write: acked, err_bus=0.
  - data_bus_rd=0 on every write ack.
- Address bits [1:0] are ignored; alignment is the master's responsibility.

Decomposition:
- Package arb_bus_pkg:
  - ADDR_W/DATA_W/BE_W/CPU_W defaults;
  - state typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD};
  - ERR_DATA = 32'hDEAD_BEEF;
  - op typedef {OP_RD, OP_WR, OP_BAD}.
- Sub-module arb_bus_slave_ram:
  - DEPTH × DATA_W array with byte-enable synchronous write;
  - combinational read of the captured index.
- FSM, counter and error checks stay in arb_bus_slave.

Test Plan:
- Write then read, WAIT_CYCLES=2, cpu=1:
  - Write 0x0000_0010 with data 0xA5A5_1234 and be=4'hF: ack 3 cycles after strobe, err=0, last_cpu=1.
  - Read back the same address: data_bus_rd=0xA5A5_1234 with ack.
- Byte enables:
  - Write 0xFFFF_FFFF with be=4'hF, then write 0x0000_0000 with be=4'b0101.
  - Read returns 0xFF00_FF00.
- Errors:
  - Read at address 0x400 with DEPTH=256 → ack, err=1, data=0xDEAD_BEEF.
  - rd_bus=wr_bus=1 → ack, err=1, memory unchanged.
- Write protect:
  - WP_MASK=4'b1000, write from cpu=3 → ack with err=1; a subsequent read by cpu=0 shows the old value.
  - The same write from cpu=2 → err=0, committed.
- HOLD and back-to-back:
  - Keep rd_bus high 4 cycles after ack → exactly one ack pulse.
  - Drop for one cycle, raise again with cpu=2 → second ack after WAIT_CYCLES+1, last_cpu=2.
- Reset mid-transaction:
  - Assert reset_n=0 during WAIT of a write to 0x20 → no ack, outputs zero.
  - After release, reading 0x20 returns its pre-write value; with WAIT_CYCLES=0 the read ack arrives 1 cycle after strobe.
